// File: rtl/data_cmem_bank.sv
// Run-time loadable, multi-bank FIR coefficient memory with an atomic shadow->active swap.
// Optional macro DATA_CMEM_BANK_SYM_EN: symmetric-tap storage (half-depth banks, folded read address).
module data_cmem_bank #(
    parameter int DW    = 16,
    parameter int AW    = 6,
    parameter int NBANK = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_start,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic signed [DW-1:0]                 wr_data,
    output logic                                 load_done,
    input  logic                                 swap_req,
    output logic                                 swap_err,
    output logic [((NBANK > 1) ? $clog2(NBANK) : 1)-1:0] active_bank,
    input  logic                                 rd_en,
    input  logic [AW-1:0]                        rd_addr,
    output logic signed [DW-1:0]                 rd_q,
    output logic                                 rd_qv
);
    localparam int NT = 1 << AW;
`ifdef DATA_CMEM_BANK_SYM_EN
    localparam int ND = NT / 2;
`else
    localparam int ND = NT;
`endif
    localparam int DAW = $clog2(ND);
    localparam int BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam logic [DAW-1:0] LAST     = DAW'(ND - 1);
    localparam logic [BW-1:0]  BANK_TOP = BW'(NBANK - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } state_t;

    state_t               state;
    logic [DAW-1:0]       wr_ptr;
    logic [BW-1:0]        shadow;
    logic                 wr_acc;
    logic [DAW-1:0]       rd_idx;
    logic signed [DW-1:0] mem [NBANK][ND];

    assign shadow    = (active_bank == BANK_TOP) ? '0 : active_bank + BW'(1);
    assign wr_ready  = (state == LOAD) && !wr_start;
    assign load_done = (state == FULL);
    assign wr_acc    = wr_valid && wr_ready;

`ifdef DATA_CMEM_BANK_SYM_EN
    // Upper half of the tap range mirrors the lower half: NT-1-a is the bitwise complement.
    assign rd_idx = rd_addr[AW-1] ? ~rd_addr[DAW-1:0] : rd_addr[DAW-1:0];
`else
    assign rd_idx = rd_addr;
`endif

    // Loader / swap control; wr_start overrides everything else in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            active_bank <= '0;
            swap_err    <= 1'b0;
        end else begin
            swap_err <= swap_req && !wr_start && (state != FULL);
            if (wr_start) begin
                state  <= LOAD;
                wr_ptr <= '0;
            end else begin
                case (state)
                    LOAD: begin
                        if (wr_acc) begin
                            if (wr_ptr == LAST) begin
                                state <= FULL;
                            end else begin
                                wr_ptr <= wr_ptr + DAW'(1);
                            end
                        end
                    end
                    FULL: begin
                        if (swap_req) begin
                            active_bank <= shadow;
                            state       <= IDLE;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    // Coefficient storage: only the shadow bank is ever written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int i = 0; i < ND; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (wr_acc) begin
            mem[shadow][wr_ptr] <= wr_data;
        end
    end

    // Read stage: bank index sampled at issue, so a read in the swap cycle sees the old set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            rd_qv <= 1'b0;
        end else begin
            rd_qv <= rd_en;
            if (rd_en) begin
                rd_q <= mem[active_bank][rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_data_cmem_bank.sv
// Randomised scoreboard bench for data_cmem_bank against a tap-level behavioural model.
module tb_data_cmem_bank;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int NBANK = 2;
    localparam int NT    = 1 << AW;
`ifdef DATA_CMEM_BANK_SYM_EN
    localparam int NW = NT / 2;
    localparam logic [15:0] BASE = 16'hA000;
`else
    localparam int NW = NT;
    localparam logic [15:0] BASE = 16'h0100;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 wr_start = 1'b0;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic signed [DW-1:0] wr_data = '0;
    logic                 load_done;
    logic                 swap_req = 1'b0;
    logic                 swap_err;
    logic [0:0]           active_bank;
    logic                 rd_en = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic signed [DW-1:0] rd_q;
    logic                 rd_qv;

    data_cmem_bank #(.DW(DW), .AW(AW), .NBANK(NBANK)) dut (
        .clk(clk), .rst(rst),
        .wr_start(wr_start), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .load_done(load_done), .swap_req(swap_req), .swap_err(swap_err),
        .active_bank(active_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_q(rd_q), .rd_qv(rd_qv)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [15:0] d;
    } rd_exp_t;

    rd_exp_t     sbq[$];
    logic [15:0] exp_last = '0;
    int          errors = 0;
    int          checks = 0;

    // Behavioural model: tap arrays per bank, active index, loader phase and word count
    logic [15:0] mb [NBANK][NT];
    int          mact  = 0;
    int          mphase = 0;   // 0 idle, 1 loading, 2 loaded
    int          mcnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(input int bank, input int a);
        int idx;
        idx = a;
`ifdef DATA_CMEM_BANK_SYM_EN
        if (a >= NT / 2) idx = NT - 1 - a;
`endif
        return mb[bank][idx];
    endfunction

    task automatic model_clear();
        for (int b = 0; b < NBANK; b++)
            for (int i = 0; i < NT; i++) mb[b][i] = '0;
        mact = 0; mphase = 0; mcnt = 0;
    endtask

    // One clock of stimulus; expected read result goes to the scoreboard, control is checked here
    task automatic step(input bit ws, input bit wv, input logic [15:0] wd,
                        input bit sr, input bit re, input logic [AW-1:0] ra);
        rd_exp_t e;
        bit exp_err;
        @(negedge clk);
        wr_start = ws; wr_valid = wv; wr_data = wd; swap_req = sr; rd_en = re; rd_addr = ra;
        #1;
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, (mphase == 1) && !ws});
        e.v = re;
        e.d = re ? model_read(mact, int'(ra)) : 16'h0;
        sbq.push_back(e);
        exp_err = sr && !ws && (mphase != 2);
        if (ws) begin
            mphase = 1; mcnt = 0;
        end else if (mphase == 1 && wv) begin
            mb[(mact + 1) % NBANK][mcnt] = wd;
            mcnt++;
            if (mcnt == NW) mphase = 2;
        end else if (mphase == 2 && sr) begin
            mact = (mact + 1) % NBANK;
            mphase = 0;
        end
        @(posedge clk);
        #2;
        chk("swap_err", {31'd0, swap_err}, {31'd0, exp_err});
        chk("load_done", {31'd0, load_done}, {31'd0, mphase == 2});
        chk("active_bank", {31'd0, active_bank}, mact);
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 0, 0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        wr_start = 0; wr_valid = 0; swap_req = 0; rd_en = 0;
        #1;
        chk("rst_rd_q", {16'd0, rd_q}, 32'd0);
        chk("rst_rd_qv", {31'd0, rd_qv}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_swap_err", {31'd0, swap_err}, 32'd0);
        chk("rst_active_bank", {31'd0, active_bank}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        sbq.delete();
        exp_last = '0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: one scoreboard entry per issued cycle, rd_q must hold when no read completes
    initial begin
        rd_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rd_qv", {31'd0, rd_qv}, {31'd0, e.v});
                if (e.v) exp_last = e.d;
                chk("rd_q", {16'd0, rd_q}, {16'd0, exp_last});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        do_reset();

        // Fresh reset: every tap reads zero
        for (int a = 0; a < NT; a++) step(0, 0, 16'h0, 0, 1, AW'(a));
        idle();

        // Full load with random gaps and interleaved reads, then swap with a same-cycle read
        step(1, 0, 16'h0, 0, 0, '0);
        for (int i = 0; i < NW; ) begin
            if ($urandom_range(0, 3) == 0) begin
                step(0, 0, 16'($urandom), 0, $urandom_range(0, 1), AW'($urandom));
            end else begin
                step(0, 1, BASE + 16'(i), 0, $urandom_range(0, 1), AW'($urandom));
                i++;
            end
        end
        step(0, 1, 16'hDEAD, 0, 0, '0);          // extra word in FULL is not taken
        step(0, 0, 16'h0, 1, 1, AW'(3));         // swap cycle read -> old bank
        step(0, 0, 16'h0, 0, 1, AW'(3));
        step(0, 0, 16'h0, 0, 1, AW'(5));
        step(0, 0, 16'h0, 0, 1, AW'(NT - 1));
        step(0, 0, 16'h0, 0, 1, AW'(NT / 2));
        step(0, 0, 16'h0, 0, 1, AW'(NT / 2 - 1));
        idle();

        // swap_req mid-load is rejected; wr_start with wr_valid drops the word and restarts
        step(1, 0, 16'h0, 0, 0, '0);
        for (int i = 0; i < 10; i++) step(0, 1, 16'h2000 + 16'(i), 0, 0, '0);
        step(0, 1, 16'h200A, 1, 0, '0);
        step(1, 1, 16'h7777, 0, 0, '0);
        for (int i = 0; i < NW; i++) step(0, 1, 16'($urandom), 0, 1, AW'($urandom));
        step(0, 0, 16'h0, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0, 1, AW'($urandom));
        idle();

        // Reset part way through a load
        step(1, 0, 16'h0, 0, 0, '0);
        for (int i = 0; i < 30; i++) step(0, 1, 16'h3000 + 16'(i), 0, 0, '0);
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0, 1, AW'($urandom));

        // Random traffic
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7, 16'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1), AW'($urandom));
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_cmem_bank.md
Name: data_cmem_bank

Overview:
- Parametrised, run-time loadable FIR coefficient memory.
- Holds NBANK banks of 2^AW signed DW-bit coefficients.
- Filter datapath reads the active bank with 1-cycle latency while a host streams a new coefficient set into the shadow bank.
- An atomic swap makes the new set active, so coefficients can be updated without glitching the filter.

Parameters:
- DW, 16, coefficient width in bits (two's complement).
- AW, 6, tap address width; taps per bank NT = 2^AW.
- NBANK, 2, number of banks (>=2); shadow bank = (active+1) mod NBANK.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wr_start  in  1  begin new load into shadow bank; write pointer := 0
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  loader accepts word; = (state==LOAD) && !wr_start
- wr_data  in  DW  coefficient, written in ascending tap order
- load_done  out  1  shadow bank fully loaded (state FULL)
- swap_req  in  1  request shadow->active swap
- swap_err  out  1  1-cycle pulse: swap_req outside FULL
- active_bank  out  max(1,$clog2(NBANK))  current active bank index
- rd_en  in  1  read strobe
- rd_addr  in  AW  tap index
- rd_q  out  DW  coefficient, registered
- rd_qv  out  1  rd_q valid

Behaviour:
- Reset (async assert): all bank storage = 0, active_bank = 0, state = IDLE, wr_ptr = 0, rd_q = 0, rd_qv = 0, load_done = 0, swap_err = 0.
- States:
  - IDLE: wr_start -> LOAD.
  - LOAD: each wr_valid && wr_ready writes wr_data to shadow[wr_ptr], wr_ptr++. The write of the last word (wr_ptr == LAST) -> FULL.
  - FULL: load_done = 1, wr_ready = 0. swap_req -> IDLE with active_bank := shadow. wr_start -> LOAD (loaded set discarded).
- LAST = NT-1, or NT/2-1 with CMEM_SYM_EN.
- wr_start in any state restarts: wr_ptr := 0, state := LOAD. It takes priority over a same-cycle wr_valid (word not accepted) and over a same-cycle swap_req (no swap, no swap_err).
- swap_req in IDLE or LOAD: ignored; swap_err = 1 for one cycle.
- Read path: rd_en at edge N -> rd_q = active[rd_addr] and rd_qv = 1 after edge N+1. rd_en low -> rd_qv = 0 and rd_q holds its last value.
- Read uses the active_bank value at issue: a read issued in the swap cycle returns the old bank; reads issued from the next cycle return the new bank.
- Writes never target the active bank. Read/write to the same physical bank cannot occur.
- Reset mid-load: contents cleared, state IDLE, any partial load lost.
- No wrap-around of wr_ptr: words presented in FULL are not accepted (wr_ready = 0).

Optional Feature:
- Macro: DATA_CMEM_BANK_SYM_EN.
- Defined:
  - Symmetric-tap mode: each bank stores NT/2 words; loader accepts exactly NT/2 words (taps 0..NT/2-1).
  - Read address a >= NT/2 maps to NT-1-a, so rd_addr 63 returns tap 0 at AW=6.
  - Halves storage.
- Undefined: full NT words stored and loaded; no address folding.

Test Plan:
- Reset, then rd_en with rd_addr=0..63 -> every rd_q = 16'h0000, rd_qv high exactly one cycle after each rd_en.
- wr_start, stream 64 words 16'h0100+i, swap_req -> load_done high after 64th accept; active_bank 0->1; read addr 5 returns 16'h0105.
- Read issued in the swap cycle at addr 3 -> returns old-bank value 16'h0000; read next cycle -> 16'h0103.
- swap_req during LOAD after 10 words -> swap_err one-cycle pulse, active_bank unchanged, load continues. wr_start with wr_valid in same cycle -> word dropped, wr_ptr=0.
- Assert rst mid-load (word 30) -> all outputs reset values immediately, wr_ready=0, subsequent reads 16'h0000.
- With DATA_CMEM_BANK_SYM_EN: load 32 words 16'hA000+i, swap -> rd_addr 63 gives 16'hA000, rd_addr 32 gives 16'hA01F, rd_addr 31 gives 16'hA01F, 33rd wr_valid not accepted.
